// File: rtl/down_timer.sv
// Loadable down counter/timer with valid/ready load, pause/resume and optional auto-reload.
// Optional prescaler enabled by defining DOWN_TIMER_PRESCALE_EN (PRESCALE_DIV clocks per decrement).
//
// state   | meaning
// IDLE    | nothing loaded since reset; only a load leaves
// ARMED   | value loaded or run paused; start begins/resumes counting
// RUN     | counting down; loads refused
// EXPIRED | reached zero; start restarts from the reload value
module down_timer #(
  parameter int WIDTH        = 8,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RUN     = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_d;
  logic             tick;

  if (PRESCALE_DIV < 2 || PRESCALE_DIV > 16) begin : g_bad_div
    $error("down_timer: PRESCALE_DIV must be in 2..16");
  end

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE_DIV + 1);
  logic [PW-1:0] presc_q;

  assign tick = (presc_q == PW'(PRESCALE_DIV - 1));

  // Held at zero outside RUN so every run segment starts a full period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (state_q != S_RUN || state_d != S_RUN || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (stop) begin
          state_d = S_ARMED;
        end else if (tick) begin
          if (count > WIDTH'(1)) begin
            count_d = count - WIDTH'(1);
          end else begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = S_EXPIRED;
            end
          end
        end
      end
      default: begin
        if (load_valid) begin
          count_d  = load_value;
          reload_d = load_value;
          state_d  = S_ARMED;
        end else if (start && state_q == S_ARMED) begin
          if (count != '0) begin
            state_d = S_RUN;
          end else begin
            done_d  = 1'b1;
            state_d = S_EXPIRED;
          end
        end else if (start && state_q == S_EXPIRED) begin
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count    <= '0;
      reload_q <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      reload_q <= reload_d;
      done     <= done_d;
      busy     <= (state_d == S_RUN);
    end
  end

  assign state      = state_q;
  assign load_ready = (state_q != S_RUN);

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer; expectations are hand-computed per step.
// Runs the prescale scenario instead of the per-cycle scenarios when DOWN_TIMER_PRESCALE_EN is defined.
module tb_down_timer;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int checks   = 0;
  int failures = 0;

  down_timer #(.WIDTH(WIDTH), .PRESCALE_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input int s, input int d, input int b, input int lr);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".state"}, int'(state), s);
    chk({tag, ".done"}, int'(done), d);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".load_ready"}, int'(load_ready), lr);
  endtask

  task automatic do_load(input int v);
    load_valid = 1'b1;
    load_value = WIDTH'(v);
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load_valid = 1'b0; load_value = '0;
    start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0, 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk_all("idle_start", 0, 0, 0, 0, 1);
    start = 1'b0;

`ifdef DOWN_TIMER_PRESCALE_EN
    do_load(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("ps_entry", 2, 2, 0, 1, 0);
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("ps_count_e%0d", e), int'(count), (e < 4) ? 2 : (e < 8) ? 1 : 0);
      chk($sformatf("ps_done_e%0d", e), int'(done), (e == 8) ? 1 : 0);
    end
    chk("ps_state_end", int'(state), 3);
`else
    // basic countdown
    do_load(5);
    chk_all("b_load", 5, 1, 0, 0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("b_entry", 5, 2, 0, 1, 0);
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk($sformatf("b_count_%0d", i), int'(count), i);
      chk($sformatf("b_done_%0d", i), int'(done), (i == 0) ? 1 : 0);
    end
    chk_all("b_end", 0, 3, 1, 0, 1);
    tick();
    chk("b_done_clear", int'(done), 0);

    // auto-reload, then drop it
    do_load(3);
    auto_reload = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("ar_entry", 3, 2, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("ar_count_%0d", k), int'(count), (k % 3 == 0) ? 2 : (k % 3 == 1) ? 1 : 3);
      chk($sformatf("ar_done_%0d", k), int'(done), (k % 3 == 2) ? 1 : 0);
      chk($sformatf("ar_busy_%0d", k), int'(busy), 1);
    end
    auto_reload = 1'b0;
    tick(); chk("ar_off_2", int'(count), 2);
    tick(); chk("ar_off_1", int'(count), 1);
    tick();
    chk_all("ar_off_end", 0, 3, 1, 0, 1);

    // pause / resume
    do_load(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 9; i >= 6; i--) begin
      tick();
      chk($sformatf("p_count_%0d", i), int'(count), i);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("p_paused", 6, 1, 0, 0, 1);
    tick();
    chk_all("p_hold", 6, 1, 0, 0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("p_resume", 6, 2, 0, 1, 0);
    tick(); chk("p_count_5", int'(count), 5);
    tick(); chk("p_count_4", int'(count), 4);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("p_stop_wins", 4, 1, 0, 0, 1);

    // load has priority over start; then load of 0 expires at once
    load_valid = 1'b1; load_value = '0;
    tick();
    load_valid = 1'b0;
    chk_all("z_load_prio", 0, 1, 0, 0, 1);
    tick();
    chk_all("z_expire", 0, 3, 1, 0, 1);
    start = 1'b0;
    tick();
    chk("z_done_clear", int'(done), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("z_restart_zero", 0, 3, 1, 0, 1);

    // reload value of 1 with auto-reload: done every cycle
    do_load(1);
    auto_reload = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("r1_%0d", k), 1, 2, 1, 1, 0);
    end
    auto_reload = 1'b0;
    tick();
    chk_all("r1_end", 0, 3, 1, 0, 1);

    // 255 with a refused load during RUN, no wrap
    do_load(255);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_valid = 1'b1; load_value = 8'd7;
    chk("m_load_ready_run", int'(load_ready), 0);
    tick();
    load_valid = 1'b0;
    chk("m_load_ignored", int'(count), 254);
    for (int i = 253; i >= 0; i--) begin
      tick();
      chk($sformatf("m_count_%0d", i), int'(count), i);
    end
    chk_all("m_end", 0, 3, 1, 0, 1);
    tick();
    chk("m_no_wrap", int'(count), 0);

    // asynchronous reset mid-count
    do_load(20);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("rm_pre", int'(count), 18);
    #2 rst = 1'b0;
    #1;
    chk_all("rm_async", 0, 0, 0, 0, 1);
    tick();
    chk_all("rm_held", 0, 0, 0, 0, 1);
    rst = 1'b1;
    tick();
    chk_all("rm_release", 0, 0, 0, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable 8-bit down counter/timer; the counting-down complement of the team's 8-bit up counter.
- Software or an upstream FSM loads a start value over a valid/ready handshake, then starts the count.
- The block decrements to zero, pulses done, and either stops or auto-reloads.
- Used as a timeout/interval generator next to the up counter in the same clock domain.

Parameters:
- WIDTH, 8, counter and load-value width.
- PRESCALE_DIV, 4, clock cycles per decrement; used only when DOWN_TIMER_PRESCALE_EN is defined; legal range 2..16.

Ports:
- clk  input  1  single clock; rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load.
- load_value  input  WIDTH  value to load.
- start  input  1  level-sampled start/resume command.
- stop  input  1  level-sampled pause command.
- auto_reload  input  1  reload on expiry instead of halting.
- count  output  WIDTH  current count (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle expiry pulse (registered).
- state  output  2  FSM state: 0=IDLE, 1=ARMED, 2=RUN, 3=EXPIRED.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, reload_reg=0, state=IDLE, busy=0, done=0, load_ready=1.
  - Reset mid-RUN aborts immediately; no done pulse.
- load_ready=1 in IDLE, ARMED and EXPIRED; 0 in RUN. Loads are never accepted while running.
- Load handshake: load_valid&&load_ready on an edge → count<=load_value, reload_reg<=load_value, state<=ARMED.
  - A load has priority over start in the same cycle; start is ignored that cycle.
- IDLE: only a load leaves IDLE. start and stop are ignored.
- ARMED, start=1:
  - count!=0 → state<=RUN.
  - count==0 → done=1 for one cycle, state<=EXPIRED.
- RUN, once per cycle (once per tick with prescale):
  - stop=1 (priority over everything in RUN): state<=ARMED, count holds, no done. Resume with start.
  - count>1: count<=count-1.
  - count==1, auto_reload=0: count<=0, done=1 for that cycle, state<=EXPIRED.
  - count==1, auto_reload=1: count<=reload_reg, done=1, state stays RUN. Period = reload_reg cycles.
  - reload_reg==1 with auto_reload=1: done is high every cycle.
- EXPIRED, start=1:
  - reload_reg!=0 → count<=reload_reg, state<=RUN.
  - reload_reg==0 → done pulses again, state stays EXPIRED.
- No underflow: count never wraps from 0 to 2^WIDTH-1.
- busy == (state==RUN), registered with the state.
- Latency:
  - Load accepted at edge N; ARMED is visible after N.
  - Start sampled at edge M; RUN after M; first decrement at edge M+1.
  - A load of L expires L edges after the RUN-entry edge, with done coincident with count==0.
- auto_reload is sampled only at the terminal step.

Optional Feature:
- Macro: DOWN_TIMER_PRESCALE_EN.
- Defined:
  - An internal prescaler generates a tick every PRESCALE_DIV cycles while in RUN.
  - Decrement, terminal and reload actions occur only on tick cycles.
  - The prescaler clears to 0 on entering RUN, on stop, and on reset.
  - The first decrement occurs PRESCALE_DIV edges after RUN entry. done still lasts exactly one clock.
- Undefined: decrement every cycle in RUN. PRESCALE_DIV is unused and no prescaler logic is present.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release → count=0, state=0, load_ready=1, busy=0, done=0. Start in IDLE → no change.
- Basic countdown: load 5, start one cycle, auto_reload=0 → count 5,4,3,2,1,0 over consecutive edges; done high only with count=0; state=3; load_ready=1.
- Auto-reload: load 3, auto_reload=1, start → sequence 3,2,1,3,2,1…; done every 3rd cycle; busy stays 1. Drop auto_reload → next expiry halts at 0.
- Pause/resume: load 10, start, assert stop when count=6 → count holds at 6, state=1. Start → continues 5,4…. Stop+start together in RUN → pause wins.
- Boundaries:
  - Load 0 + start → done one cycle, state=3, count=0.
  - Load 255 → 255 decrements with no wrap.
  - load_valid during RUN → load_ready=0 and count unaffected.
  - rst=0 mid-count → immediate reset values.
- Prescale (macro defined, PRESCALE_DIV=4): load 2, start → count changes every 4 cycles. done occurs 8 edges after RUN entry, width 1 cycle.
